// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES-128 key schedule: FSM encoding, round-key word
// layout, rcon constants and the forward S-box table used by the lookup stage.
package aes_key_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;
  localparam logic [1:0] ST_EXP  = 2'd3;

  localparam logic [3:0] AES128_LAST_ROUND = 4'd10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  // w0 occupies the most significant word, matching the round stage's XOR term
  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } rk_words_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_sbox4.sv
// Four parallel forward S-box lookups with a registered read (one cycle latency),
// written so each byte maps onto a ROM-style block RAM.
module key_sbox4
  import aes_key_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] byte_reg;

    always_ff @(posedge clk) begin
      byte_reg <= SBOX[word[8*gi +: 8]];
    end

    assign sub_word[8*gi +: 8] = byte_reg;
  end

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams the eleven
// round keys, spending one emit, one S-box lookup and one XOR-chain cycle per round.
module aes128_key_expand
  import aes_key_pkg::*;
#(
  parameter int ZERO_IDLE = 1,
  parameter int NUM_RK    = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  // Only the AES-128 count of eleven round keys is meaningful here.
  localparam logic [3:0] LAST_ROUND = 4'(NUM_RK - 1);

  logic [1:0]  state_reg;
  rk_words_t   key_reg;
  logic [7:0]  rcon_reg;
  logic [3:0]  round_reg;

  logic [31:0] rot_word;
  logic [31:0] sub_word;
  logic [31:0] t_word;
  logic [31:0] w0_next;
  logic [31:0] w1_next;
  logic [31:0] w2_next;
  logic [31:0] w3_next;

  // The lookup runs every cycle; its result is only consumed in EXP, one cycle after SUB.
  assign rot_word = {key_reg.w3[23:0], key_reg.w3[31:24]};

  key_sbox4 u_sbox (
    .clk      (clk),
    .word     (rot_word),
    .sub_word (sub_word)
  );

  assign t_word  = sub_word ^ {rcon_reg, 24'h0};
  assign w0_next = key_reg.w0 ^ t_word;
  assign w1_next = key_reg.w1 ^ w0_next;
  assign w2_next = key_reg.w2 ^ w1_next;
  assign w3_next = key_reg.w3 ^ w2_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      key_reg   <= '0;
      rcon_reg  <= RCON_INIT;
      round_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (key_valid) begin
            key_reg   <= key_in;
            rcon_reg  <= RCON_INIT;
            round_reg <= '0;
            state_reg <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (rk_ready) begin
            state_reg <= (round_reg == LAST_ROUND) ? ST_IDLE : ST_SUB;
          end
        end
        ST_SUB: begin
          state_reg <= ST_EXP;
        end
        ST_EXP: begin
          key_reg   <= '{w0: w0_next, w1: w1_next, w2: w2_next, w3: w3_next};
          rcon_reg  <= xtime(rcon_reg);
          round_reg <= round_reg + 4'd1;
          state_reg <= ST_EMIT;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign key_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rk_valid  = (state_reg == ST_EMIT);
  assign rk_round  = round_reg;

  if (ZERO_IDLE != 0) begin : g_zero_idle
    assign rk_out = rk_valid ? key_reg : '0;
  end else begin : g_hold_idle
    assign rk_out = key_reg;
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand against a FIPS-197 style word-by-word
// key expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  logic [3:0]   got_round [11];
  int           got_t [11];
  int           got_cnt;
  int           stall_bad;
  int           t_send;
  int           t_done;
  logic         ready_done;

  aes128_key_expand #(.ZERO_IDLE(1), .NUM_RK(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic send_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    t_send = cyc;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Collects up to 11 round keys, holding rk_ready low for 'stall' cycles per key.
  task automatic collect(input int stall);
    int guard;
    guard = 0;
    got_cnt = 0;
    stall_bad = 0;
    for (int r = 0; r < 11; r++) begin
      got_rk[r] = 'x;
      got_round[r] = 'x;
      got_t[r] = -1;
    end
    while (got_cnt < 11 && guard < 2000) begin
      if (rk_valid === 1'b1) begin
        got_rk[got_cnt] = rk_out;
        got_round[got_cnt] = rk_round;
        got_t[got_cnt] = cyc;
        for (int s = 0; s < stall; s++) begin
          rk_ready = 1'b0;
          @(negedge clk);
          guard++;
          if (rk_valid !== 1'b1 || rk_out !== got_rk[got_cnt] || rk_round !== got_round[got_cnt])
            stall_bad++;
        end
        rk_ready = 1'b1;
        @(negedge clk);
        guard++;
        got_cnt++;
      end else begin
        @(negedge clk);
        guard++;
      end
    end
    t_done = cyc;
    ready_done = key_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rk_valid: got %b, expected 0", rk_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_key_ready: got %b, expected 1", key_ready); end
    tests_run++; if (rk_out !== 128'h0) begin tests_failed++; $display("FAIL reset_rk_out: got %h, expected 0", rk_out); end
    tests_run++; if (rk_round !== 4'd0) begin tests_failed++; $display("FAIL reset_rk_round: got %0d, expected 0", rk_round); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0 || key_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_idle: got busy=%b ready=%b, expected 0/1", busy, key_ready); end
  endtask

  task automatic test_fips();
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    rk_ready = 1'b1;
    send_key(k);
    collect(0);
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL fips_count: got %0d, expected 11", got_cnt); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) begin
        tests_failed++; $display("FAIL fips_rk%0d: got %h/%0d, expected %h/%0d", r, got_rk[r], got_round[r], exp_rk[r], r);
      end
    end
    tests_run++; if (got_rk[0] !== k) begin tests_failed++; $display("FAIL fips_round0: got %h, expected %h", got_rk[0], k); end
    tests_run++; if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin tests_failed++; $display("FAIL fips_round1: got %h, expected a0fafe1788542cb123a339392a6c7605", got_rk[1]); end
    tests_run++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin tests_failed++; $display("FAIL fips_round10: got %h, expected d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); end
    tests_run++; if (got_t[0] !== t_send + 1) begin tests_failed++; $display("FAIL fips_t_round0: got %0d, expected %0d", got_t[0], t_send + 1); end
    tests_run++; if (got_t[10] !== got_t[0] + 30) begin tests_failed++; $display("FAIL fips_t_round10: got %0d, expected %0d", got_t[10], got_t[0] + 30); end
    tests_run++; if (t_done !== got_t[0] + 31 || ready_done !== 1'b1) begin tests_failed++; $display("FAIL fips_key_ready: got t=%0d ready=%b, expected t=%0d ready=1", t_done, ready_done, got_t[0] + 31); end
  endtask

  task automatic test_stall();
    logic [127:0] k;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    rk_ready = 1'b0;
    send_key(k);
    collect(5);
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL stall_count: got %0d, expected 11", got_cnt); end
    tests_run++; if (stall_bad !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changes, expected 0", stall_bad); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) begin
        tests_failed++; $display("FAIL stall_rk%0d: got %h/%0d, expected %h/%0d", r, got_rk[r], got_round[r], exp_rk[r], r);
      end
    end
    tests_run++; if (got_t[1] - got_t[0] !== 8) begin tests_failed++; $display("FAIL stall_spacing: got %0d, expected 8", got_t[1] - got_t[0]); end
  endtask

  task automatic test_zero();
    model_expand(128'h0);
    rk_ready = 1'b1;
    send_key(128'h0);
    collect(0);
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL zero_count: got %0d, expected 11", got_cnt); end
    tests_run++; if (got_rk[1] !== 128'h62636363626363636263636362636363) begin tests_failed++; $display("FAIL zero_round1: got %h, expected 62636363626363636263636362636363", got_rk[1]); end
    tests_run++; if (got_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin tests_failed++; $display("FAIL zero_round10: got %h, expected b4ef5bcb3e92e21123e951cf6f8f188e", got_rk[10]); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r]) begin tests_failed++; $display("FAIL zero_rk%0d: got %h, expected %h", r, got_rk[r], exp_rk[r]); end
    end
  endtask

  task automatic test_ignore();
    logic [127:0] a;
    logic [127:0] b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    model_expand(a);
    rk_ready = 1'b1;
    send_key(a);
    fork
      collect(0);
      begin
        for (int j = 0; j < 12; j++) begin
          key_in = b;
          key_valid = j[0];
          @(negedge clk);
          tests_run++; if (key_ready !== 1'b0) begin tests_failed++; $display("FAIL ignore_key_ready: got %b, expected 0", key_ready); end
        end
        key_valid = 1'b0;
      end
    join
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL ignore_count: got %0d, expected 11", got_cnt); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r]) begin tests_failed++; $display("FAIL ignore_rk%0d: got %h, expected %h", r, got_rk[r], exp_rk[r]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    logic [127:0] b;
    int guard;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    rk_ready = 1'b1;
    send_key(a);
    guard = 0;
    while (!(rk_valid === 1'b1 && rk_round === 4'd4) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    tests_run++; if (guard >= 200) begin tests_failed++; $display("FAIL rstmid_reach_r4: got timeout, expected round 4"); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_rk_valid: got %b, expected 0", rk_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    tests_run++; if (key_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_key_ready: got %b, expected 1", key_ready); end
    tests_run++; if (rk_out !== 128'h0 || rk_round !== 4'd0) begin tests_failed++; $display("FAIL rstmid_out: got %h/%0d, expected 0/0", rk_out, rk_round); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_partial: got %b, expected 0", rk_valid); end
    model_expand(b);
    send_key(b);
    collect(0);
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL rstmid_count: got %0d, expected 11", got_cnt); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) begin
        tests_failed++; $display("FAIL rstmid_rk%0d: got %h/%0d, expected %h/%0d", r, got_rk[r], got_round[r], exp_rk[r], r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    int t_a0;
    int t_a_done;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    model_expand(a);
    rk_ready = 1'b1;
    key_in = a;
    key_valid = 1'b1;
    @(negedge clk);
    key_in = b;
    collect(0);
    t_a0 = got_t[0];
    t_a_done = t_done;
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL b2b_a_count: got %0d, expected 11", got_cnt); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r]) begin tests_failed++; $display("FAIL b2b_a_rk%0d: got %h, expected %h", r, got_rk[r], exp_rk[r]); end
    end
    tests_run++; if (ready_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready: got %b, expected 1", ready_done); end
    model_expand(b);
    collect(0);
    key_valid = 1'b0;
    tests_run++; if (got_cnt !== 11) begin tests_failed++; $display("FAIL b2b_b_count: got %0d, expected 11", got_cnt); end
    for (int r = 0; r < 11; r++) begin
      tests_run++;
      if (got_rk[r] !== exp_rk[r]) begin tests_failed++; $display("FAIL b2b_b_rk%0d: got %h, expected %h", r, got_rk[r], exp_rk[r]); end
    end
    tests_run++; if (got_t[0] !== t_a_done + 1 || got_t[0] !== t_a0 + 32) begin tests_failed++; $display("FAIL b2b_b_t0: got %0d, expected %0d", got_t[0], t_a0 + 32); end
  endtask

  task automatic test_random();
    logic [127:0] k;
    int stall;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      stall = $urandom_range(0, 2);
      model_expand(k);
      send_key(k);
      collect(stall);
      tests_run++; if (got_cnt !== 11 || stall_bad !== 0) begin tests_failed++; $display("FAIL rand%0d_count: got %0d/%0d, expected 11/0", n, got_cnt, stall_bad); end
      for (int r = 0; r < 11; r++) begin
        tests_run++;
        if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) begin
          tests_failed++; $display("FAIL rand%0d_rk%0d: got %h/%0d, expected %h/%0d", n, r, got_rk[r], got_round[r], exp_rk[r], r);
        end
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_zero();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
